// File: rtl/vga_sync_generator_pkg.sv
// ----------------------------------------------------------------------------
// vga_sync_generator_pkg
//
// Shared definitions for the VGA sync generator and its axis timers.
//  - phase_e : per-axis phase encoding (SYNC, BACK, ACTIVE, FRONT), 2 bits.
//  - VGA_*   : default 640x480@60 timing constants. The colour manager uses
//              the same porch values, so both blocks agree on line and frame
//              geometry.
//  - barColour : colour lookup for the optional vertical colour-bar pattern.
// ----------------------------------------------------------------------------
package vga_sync_generator_pkg;

    // Phase order along each axis. The back porch follows sync because the
    // colour manager counts its back porch from the sync edge.
    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BACK   = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FRONT  = 2'd3
    } phase_e;

    // Horizontal timing in pixel-clock cycles.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;

    // Vertical timing in lines.
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    // Sync level while asserted (0 = active-low), pixel bus and counter widths.
    localparam logic VGA_SYNC_POL   = 1'b0;
    localparam int   VGA_DATA_WIDTH = 12;
    localparam int   VGA_CNT_WIDTH  = 10;

    // Colour of bar idx in the test pattern, left to right: white, yellow,
    // cyan, green, magenta, red, blue, black. Each 4-bit channel is either
    // fully on or fully off, so only an R/G/B on-mask is needed per bar.
    function automatic logic [11:0] barColour(input logic [2:0] idx);
        logic [2:0] rgbOn;
        case (idx)
            3'd0:    rgbOn = 3'b111;
            3'd1:    rgbOn = 3'b110;
            3'd2:    rgbOn = 3'b011;
            3'd3:    rgbOn = 3'b010;
            3'd4:    rgbOn = 3'b101;
            3'd5:    rgbOn = 3'b100;
            3'd6:    rgbOn = 3'b001;
            default: rgbOn = 3'b000;
        endcase
        return {{4{rgbOn[2]}}, {4{rgbOn[1]}}, {4{rgbOn[0]}}};
    endfunction

endpackage

// File: rtl/vga_sync_generator_axis_timer.sv
// ----------------------------------------------------------------------------
// vga_axis_timer
//
// One timing axis (horizontal or vertical). It walks SYNC -> BACK -> ACTIVE
// -> FRONT -> SYNC. Inside each phase the counter runs 0 .. len-1 on every
// tick, and it clears when the phase changes.
//
// Ports
//  clk_i       in   1          pixel clock
//  rst_i       in   1          synchronous reset, active-high
//  enable_i    in   1          run enable; low holds the axis at SYNC / 0
//  tick_i      in   1          advance strobe (every clock for H, line end for V)
//  syncLen_i   in   CNT_WIDTH  sync phase length in ticks
//  backLen_i   in   CNT_WIDTH  back porch length in ticks
//  activeLen_i in   CNT_WIDTH  active phase length in ticks
//  frontLen_i  in   CNT_WIDTH  front porch length in ticks
//  phase_o     out  2          current phase
//  count_o     out  CNT_WIDTH  position inside the current phase
//  wrap_o      out  1          pulse on the tick that leaves FRONT
// ----------------------------------------------------------------------------
module vga_axis_timer
    import vga_sync_generator_pkg::*;
#(
    parameter int CNT_WIDTH = VGA_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 tick_i,
    input  logic [CNT_WIDTH-1:0] syncLen_i,
    input  logic [CNT_WIDTH-1:0] backLen_i,
    input  logic [CNT_WIDTH-1:0] activeLen_i,
    input  logic [CNT_WIDTH-1:0] frontLen_i,
    output phase_e               phase_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 wrap_o
);

    phase_e               phase_q;
    phase_e               phase_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] phaseLen;
    phase_e               nextPhase;
    logic                 lastCount;

    // Select the length of the current phase and the phase that follows it.
    always_comb begin
        phaseLen  = syncLen_i;
        nextPhase = PH_BACK;
        unique case (phase_q)
            PH_SYNC: begin
                phaseLen  = syncLen_i;
                nextPhase = PH_BACK;
            end
            PH_BACK: begin
                phaseLen  = backLen_i;
                nextPhase = PH_ACTIVE;
            end
            PH_ACTIVE: begin
                phaseLen  = activeLen_i;
                nextPhase = PH_FRONT;
            end
            PH_FRONT: begin
                phaseLen  = frontLen_i;
                nextPhase = PH_SYNC;
            end
        endcase
    end

    assign lastCount = (count_q == (phaseLen - 1'b1));

    // On the last count of a phase, move to the next phase and restart the
    // counter. Otherwise stay in the phase and keep counting.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q + 1'b1;
        if (lastCount) begin
            phase_d = nextPhase;
            count_d = '0;
        end
    end

    // Phase FSM. Reset and a dropped enable both park the axis at SYNC with
    // the counter cleared, so a restart always begins at the sync edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            phase_q <= PH_SYNC;
            count_q <= '0;
        end else if (tick_i) begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    // The wrap pulse is gated by reset and enable so that a parked axis never
    // advances the axis it drives.
    assign wrap_o  = tick_i && enable_i && !rst_i && (phase_q == PH_FRONT) && lastCount;
    assign phase_o = phase_q;
    assign count_o = count_q;

endmodule

// File: rtl/vga_sync_generator.sv
// ----------------------------------------------------------------------------
// vga_sync_generator
//
// Generates VGA HSync/VSync and the blanked RGB pixel bus for the display
// connector. It sits downstream of the colour manager: it registers the
// colour manager's Data_VGA and forces the pixel to zero outside the visible
// window, and its syncs drive the colour manager's porch counters.
//
// Two vga_axis_timer instances provide the timing. The horizontal timer ticks
// on every clock, and the vertical timer ticks when the horizontal timer
// wraps. Every output is registered one cycle after the timer state, so
// HSync, VSync, RGB and Active_Video stay aligned with each other.
//
// Optional build macro VGA_SYNC_TEST_PATTERN_EN adds the Pattern_Sel input.
// When Pattern_Sel is high, the visible pixels show eight vertical colour
// bars instead of Data_VGA. Timing and blanking are unchanged.
//
// Ports
//  Clk           in   1           pixel clock
//  rst           in   1           synchronous reset, active-high
//  Enable        in   1           timing run enable (low = soft reset)
//  Data_VGA      in   DATA_WIDTH  pixel from the colour manager
//  Pattern_Sel   in   1           colour-bar select (VGA_SYNC_TEST_PATTERN_EN only)
//  HSync         out  1           horizontal sync, registered
//  VSync         out  1           vertical sync, registered
//  RGB           out  DATA_WIDTH  blanked pixel, registered
//  Active_Video  out  1           high while RGB carries a visible pixel
//  Line_Start    out  1           pulse on the first HSync cycle of each line
//  Frame_Start   out  1           pulse on the first HSync cycle of line 0
// ----------------------------------------------------------------------------
module vga_sync_generator
    import vga_sync_generator_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FRONT    = VGA_H_FRONT,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BACK     = VGA_H_BACK,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FRONT    = VGA_V_FRONT,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BACK     = VGA_V_BACK,
    parameter logic SYNC_POL   = VGA_SYNC_POL,
    parameter int   DATA_WIDTH = VGA_DATA_WIDTH,
    parameter int   CNT_WIDTH  = VGA_CNT_WIDTH
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] Data_VGA,
`ifdef VGA_SYNC_TEST_PATTERN_EN
    input  logic                  Pattern_Sel,
`endif
    output logic                  HSync,
    output logic                  VSync,
    output logic [DATA_WIDTH-1:0] RGB,
    output logic                  Active_Video,
    output logic                  Line_Start,
    output logic                  Frame_Start
);

    localparam logic [CNT_WIDTH-1:0] H_SYNC_LEN   = CNT_WIDTH'(H_SYNC);
    localparam logic [CNT_WIDTH-1:0] H_BACK_LEN   = CNT_WIDTH'(H_BACK);
    localparam logic [CNT_WIDTH-1:0] H_ACTIVE_LEN = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] H_FRONT_LEN  = CNT_WIDTH'(H_FRONT);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_LEN   = CNT_WIDTH'(V_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_BACK_LEN   = CNT_WIDTH'(V_BACK);
    localparam logic [CNT_WIDTH-1:0] V_ACTIVE_LEN = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_FRONT_LEN  = CNT_WIDTH'(V_FRONT);

    phase_e                hPhase;
    phase_e                vPhase;
    logic [CNT_WIDTH-1:0]  hCount;
    logic [CNT_WIDTH-1:0]  vCount;
    logic                  hWrap;
    logic                  vWrap;
    logic                  unusedFrameWrap;

    logic                  inActive;
    logic                  atLineStart;
    logic                  atFrameStart;
    logic [DATA_WIDTH-1:0] pixelSrc;

    logic                  hSync_q;
    logic                  hSync_d;
    logic                  vSync_q;
    logic                  vSync_d;
    logic [DATA_WIDTH-1:0] rgb_q;
    logic [DATA_WIDTH-1:0] rgb_d;
    logic                  activeVideo_q;
    logic                  activeVideo_d;
    logic                  lineStart_q;
    logic                  lineStart_d;
    logic                  frameStart_q;
    logic                  frameStart_d;

    vga_axis_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_hTimer (
        .clk_i       (Clk),
        .rst_i       (rst),
        .enable_i    (Enable),
        .tick_i      (1'b1),
        .syncLen_i   (H_SYNC_LEN),
        .backLen_i   (H_BACK_LEN),
        .activeLen_i (H_ACTIVE_LEN),
        .frontLen_i  (H_FRONT_LEN),
        .phase_o     (hPhase),
        .count_o     (hCount),
        .wrap_o      (hWrap)
    );

    vga_axis_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_vTimer (
        .clk_i       (Clk),
        .rst_i       (rst),
        .enable_i    (Enable),
        .tick_i      (hWrap),
        .syncLen_i   (V_SYNC_LEN),
        .backLen_i   (V_BACK_LEN),
        .activeLen_i (V_ACTIVE_LEN),
        .frontLen_i  (V_FRONT_LEN),
        .phase_o     (vPhase),
        .count_o     (vCount),
        .wrap_o      (vWrap)
    );

    // Frame start is decoded directly from the vertical state. The vertical
    // end-of-frame pulse therefore has no consumer in this block.
    assign unusedFrameWrap = vWrap;

    // Decode the current timer position. A line starts at H SYNC count 0. A
    // frame starts on the line start that is also V SYNC count 0.
    assign inActive     = (hPhase == PH_ACTIVE) && (vPhase == PH_ACTIVE);
    assign atLineStart  = (hPhase == PH_SYNC) && (hCount == '0);
    assign atFrameStart = atLineStart && (vPhase == PH_SYNC) && (vCount == '0);

`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam int BAR_WIDTH = H_ACTIVE / 8;

    logic [2:0] barIdx;

    // Find the bar for the current pixel by comparing against the bar
    // boundaries. H_ACTIVE/8 is not a power of two, so the index cannot be
    // taken from counter bits. hCount is the pixel index while the line is
    // in ACTIVE, and the result is ignored outside the visible window.
    always_comb begin
        barIdx = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (hCount >= CNT_WIDTH'(b * BAR_WIDTH)) begin
                barIdx = 3'(b);
            end
        end
    end

    assign pixelSrc = Pattern_Sel ? DATA_WIDTH'(barColour(barIdx)) : Data_VGA;
`else
    assign pixelSrc = Data_VGA;
`endif

    // Next output values, computed from the timer state of this cycle. Data_VGA
    // is sampled in the same cycle as that state.
    always_comb begin
        hSync_d       = (hPhase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vSync_d       = (vPhase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        activeVideo_d = inActive;
        rgb_d         = inActive ? pixelSrc : '0;
        lineStart_d   = atLineStart;
        frameStart_d  = atFrameStart;
    end

    // Output registers. A dropped Enable gives the same idle values as rst.
    // This keeps the start pulses from firing while the timers are parked.
    always_ff @(posedge Clk) begin
        if (rst || !Enable) begin
            hSync_q       <= ~SYNC_POL;
            vSync_q       <= ~SYNC_POL;
            rgb_q         <= '0;
            activeVideo_q <= 1'b0;
            lineStart_q   <= 1'b0;
            frameStart_q  <= 1'b0;
        end else begin
            hSync_q       <= hSync_d;
            vSync_q       <= vSync_d;
            rgb_q         <= rgb_d;
            activeVideo_q <= activeVideo_d;
            lineStart_q   <= lineStart_d;
            frameStart_q  <= frameStart_d;
        end
    end

    assign HSync        = hSync_q;
    assign VSync        = vSync_q;
    assign RGB          = rgb_q;
    assign Active_Video = activeVideo_q;
    assign Line_Start   = lineStart_q;
    assign Frame_Start  = frameStart_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_generator
//
// Scoreboard bench for vga_sync_generator. Horizontal timing uses the real
// 640x480 defaults (800-cycle lines). Vertical timing is shortened to
// 2 sync + 3 back + 8 active + 2 front = 15 lines, so a frame is
// 12000 cycles and several whole frames fit in the run.
//
// Expected output per clock edge, with x = column 0..799 and line = 0..14
// counted from the last restart:
//  HSync low for x 0..95, VSync low for lines 0..1.
//  Visible when line is 5..12 and x is 144..783.
//  Line_Start at x == 0, Frame_Start at x == 0 on line 0.
// ----------------------------------------------------------------------------
module tb_vga_sync_generator;

    localparam int TB_V_ACTIVE = 8;
    localparam int TB_V_FRONT  = 2;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BACK   = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        av;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } outVec_t;

    logic        Clk;
    logic        rst;
    logic        Enable;
    logic [11:0] Data_VGA;
    logic        patternSel;
    logic        HSync;
    logic        VSync;
    logic [11:0] RGB;
    logic        Active_Video;
    logic        Line_Start;
    logic        Frame_Start;

    outVec_t     expQ[$];
    int          statePos;
    int          dataCnt;
    int          checks;
    int          errors;
    int          edgeNum;
    logic [11:0] barRef [8];

    vga_sync_generator #(
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FRONT  (TB_V_FRONT),
        .V_SYNC   (TB_V_SYNC),
        .V_BACK   (TB_V_BACK)
    ) dut (
        .Clk          (Clk),
        .rst          (rst),
        .Enable       (Enable),
        .Data_VGA     (Data_VGA),
`ifdef VGA_SYNC_TEST_PATTERN_EN
        .Pattern_Sel  (patternSel),
`endif
        .HSync        (HSync),
        .VSync        (VSync),
        .RGB          (RGB),
        .Active_Video (Active_Video),
        .Line_Start   (Line_Start),
        .Frame_Start  (Frame_Start)
    );

    // 10-time-unit pixel clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Output expected after an edge at state position pos when data is
    // presented on Data_VGA (or the bar pattern when pat is high)
    function automatic outVec_t modelOut(input int pos, input logic [11:0] data, input logic pat);
        outVec_t v;
        int      x;
        int      line;
        x     = pos % 800;
        line  = (pos / 800) % 15;
        v.hs  = (x < 96) ? 1'b0 : 1'b1;
        v.vs  = (line < 2) ? 1'b0 : 1'b1;
        v.av  = (line >= 5) && (line < 13) && (x >= 144) && (x < 784);
        v.ls  = (x == 0);
        v.fs  = (x == 0) && (line == 0);
        v.rgb = 12'h000;
        if (v.av) begin
            v.rgb = pat ? barRef[(x - 144) / 80] : data;
        end
        return v;
    endfunction

    // Drive one cycle of inputs and push the output the next edge must produce
    task automatic applyStimulus(input logic r, input logic e, input logic [11:0] d);
        outVec_t v;
        rst      = r;
        Enable   = e;
        Data_VGA = d;
        if (r || !e) begin
            v        = '{hs: 1'b1, vs: 1'b1, av: 1'b0, ls: 1'b0, fs: 1'b0, rgb: 12'h000};
            statePos = 0;
        end else begin
            v        = modelOut(statePos, d, patternSel);
            statePos = statePos + 1;
        end
        expQ.push_back(v);
        @(negedge Clk);
    endtask

    function automatic logic [11:0] nextData(input bit vary);
        dataCnt = dataCnt + 1;
        return vary ? 12'(dataCnt * 37 + 1) : 12'hABC;
    endfunction

    task automatic runCycles(input int n, input bit vary);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, nextData(vary));
        end
    endtask

    task automatic runToFramePos(input int target, input bit vary);
        while ((statePos % 12000) != target) begin
            applyStimulus(1'b0, 1'b1, nextData(vary));
        end
    endtask

    task automatic checkOutput(input outVec_t exp, input outVec_t act);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL edge%0d outputs: got hs=%b vs=%b av=%b ls=%b fs=%b rgb=%h, expected hs=%b vs=%b av=%b ls=%b fs=%b rgb=%h",
                     edgeNum, act.hs, act.vs, act.av, act.ls, act.fs, act.rgb,
                     exp.hs, exp.vs, exp.av, exp.ls, exp.fs, exp.rgb);
        end
    endtask

    // Monitor: after each edge, compare the registered outputs with the
    // oldest pending expectation
    initial begin
        outVec_t exp;
        outVec_t act;
        edgeNum = 0;
        forever begin
            @(posedge Clk);
            #1;
            edgeNum = edgeNum + 1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                act = {HSync, VSync, Active_Video, Line_Start, Frame_Start, RGB};
                checkOutput(exp, act);
            end
        end
    end

    // Directed sequence: reset release, two full frames, a one-cycle rst at
    // line 6 column 300, a 50-cycle Enable drop at line 7 column 400, and
    // (when built) a stretch of colour bars
    initial begin
        checks     = 0;
        errors     = 0;
        statePos   = 0;
        dataCnt    = 0;
        patternSel = 1'b0;
        barRef     = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        #1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 12'hABC);
        end
        runCycles(24010, 1'b0);

        runToFramePos(6 * 800 + 300, 1'b1);
        applyStimulus(1'b1, 1'b1, 12'h5A5);
        runCycles(12010, 1'b1);

        runToFramePos(7 * 800 + 400, 1'b0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b0, 12'hABC);
        end
        runCycles(6500, 1'b0);

`ifdef VGA_SYNC_TEST_PATTERN_EN
        patternSel = 1'b1;
        runCycles(1600, 1'b1);
        patternSel = 1'b0;
`endif

        @(posedge Clk);
        #2;
        checks = checks + 1;
        if (expQ.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
